id_stage: RTL and testbench
===========================

# id_stage

Registered, parametrised RV32I instruction-decode stage with a valid/ready handshake and a two-entry skid buffer. It sits between fetch and execute in the pipelined core. It extends the single-cycle ALUop decoder to the full RV32I base set, adding register-specifier, write-enable and immediate generation, an illegal-instruction flag, and stall/flush handling.

## Interface
Parameters:
- XLEN, 32, datapath width for pc and immediate; legal values 32 and 64.
- ALUOP_W, 6, width of the ALUop field.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered instructions (branch mispredict or trap).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  pc of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_aluop  out  ALUOP_W  operation code; 0 means none/illegal.
- out_rs1, out_rs2, out_rd  out  5 each  register specifiers.
- out_rs1_en, out_rs2_en  out  1 each  register read required.
- out_rd_we  out  1  register write-back required.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  pc of the bundle.
- out_illegal  out  1  instruction not recognised.

## Operation
- Decode uses standard RV32I opcodes, funct3 and funct7. The legacy codes are kept unchanged:
  - add 1, sub 2, sll 3, jal 4, addi 5, and 6, or 7, xor 8.
  - blt 9, beq 10, srl 11, lw 12, sw 13.
- New codes:
  - slt 14, sltu 15, sra 16.
  - bne 17, bge 18, bltu 19, bgeu 20.
  - jalr 21, lui 22, auipc 23.
  - lb 24, lh 25, lbu 26, lhu 27, sb 28, sh 29.
- Immediate ALU forms (andi, ori, xori, slti, sltiu, slli, srli, srai) reuse the matching register-form code. addi keeps code 5.
- Immediate formats:
  - I, S, B, U, J sign-extended to XLEN from instr[31].
  - B and J immediates have bit 0 forced to 0.
  - U immediates are instr[31:12] followed by 12 zeros.
  - R-type immediates are 0.
- Register reads:
  - rs1_en is 1 for R, I, S, B types and jalr.
  - rs2_en is 1 for R, S, B types.
  - For other types the unused specifier field is still passed through unchanged.
- Write-back: rd_we is 1 for R, I, U types, jal and jalr, but is forced to 0 when rd == 0.
- Illegal instructions:
  - Any unmatched encoding, including a shift-immediate with bad funct7, gives aluop 0, rs1_en, rs2_en and rd_we 0, and illegal 1.
  - The bundle is still delivered, so execute can trap on it.
- Buffering: one main output register plus one skid register.
  - Transfer occurs on valid && ready at each side.
  - When the output is stalled and an input is accepted, the new bundle goes to the skid register.
  - When the output drains, the skid register moves to the output in the same edge.
- in_ready is a register: it is 1 when the skid register is empty.

## Timing
- Latency: a bundle accepted at edge N is visible on the out_* ports after edge N, i.e. out_valid is 1 in cycle N+1. Throughput is one bundle per cycle when out_ready is held at 1.
- out_* is stable while out_valid && !out_ready, per the handshake hold rule.
- Reset: while rst_n is 0, all out_* are 0, out_valid is 0 and in_ready is 1. Both buffer entries are empty. Reset takes effect asynchronously in mid-transfer.
- Flush:
  - At the next edge both entries are emptied, out_valid goes to 0 and in_ready goes to 1.
  - An in_valid in the flush cycle is dropped.
  - flush has priority over every handshake.
- Full: when both entries are occupied, in_ready is 0 in the following cycle. Input is never lost because in_ready is registered and the skid entry absorbs the in-flight beat.
- Simultaneous accept and drain with the skid register empty: the output register is reloaded directly from the new input; the skid register stays empty.

## Configuration
- DECODE_RV32M_EN defined: decode the M extension (opcode 0110011, funct7 0000001):
  - mul 32, mulh 33, mulhsu 34, mulhu 35.
  - div 36, divu 37, rem 38, remu 39.
  - These have rs1_en and rs2_en set, and rd_we per the x0 rule.
- DECODE_RV32M_EN undefined: those encodings are illegal (aluop 0, out_illegal 1).

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with out_ready 1 → next cycle out_valid 1, aluop 1, rs1 1, rs2 2, rd 3, rd_we 1, imm 0.
- addi x0,x0,-1 (0xFFF00013) → aluop 5, imm 0xFFFFFFFF, rd_we 0. jal x1,-4 (0xFFDFF0EF) → aluop 4, imm 0xFFFFFFFC.
- Hold out_ready 0 and send 3 back-to-back instructions → two are accepted, in_ready falls after the second, and release delivers them in order with no loss or duplication.
- With both entries full, assert flush together with in_valid → next cycle out_valid 0, in_ready 1, and no bundle emerges afterwards.
- Send 0xFFFFFFFF, and with DECODE_RV32M_EN undefined send mul (0x022081B3) → both give out_illegal 1, aluop 0. With the macro defined, mul gives aluop 32.
- Pull rst_n low mid-stream while out_valid is 1 → out_valid drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: registered RV32I decode stage between fetch and execute.
// Decodes one instruction per cycle into a bundle (ALU op code, register
// specifiers, read/write enables, sign-extended immediate, pc, illegal flag)
// and holds it in a main output register backed by a one-entry skid register,
// so that in_ready can be a plain flop without ever losing an input beat.
// Optional feature: define DECODE_RV32M_EN to decode the M extension
// (mul/mulh/mulhsu/mulhu/div/divu/rem/remu); otherwise those encodings are
// reported as illegal.
module id_stage #(
   parameter int XLEN    = 32,
   parameter int ALUOP_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [XLEN-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ALUOP_W-1:0] out_aluop,
   output logic [4:0]         out_rs1,
   output logic [4:0]         out_rs2,
   output logic [4:0]         out_rd,
   output logic               out_rs1_en,
   output logic               out_rs2_en,
   output logic               out_rd_we,
   output logic [XLEN-1:0]    out_imm,
   output logic [XLEN-1:0]    out_pc,
   output logic               out_illegal
);

   // ALU operation codes; the first thirteen match the older decoder
   localparam logic [ALUOP_W-1:0] OP_NONE  = ALUOP_W'(6'd0);
   localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(6'd1);
   localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(6'd2);
   localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(6'd3);
   localparam logic [ALUOP_W-1:0] OP_JAL   = ALUOP_W'(6'd4);
   localparam logic [ALUOP_W-1:0] OP_ADDI  = ALUOP_W'(6'd5);
   localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(6'd6);
   localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(6'd7);
   localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(6'd8);
   localparam logic [ALUOP_W-1:0] OP_BLT   = ALUOP_W'(6'd9);
   localparam logic [ALUOP_W-1:0] OP_BEQ   = ALUOP_W'(6'd10);
   localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(6'd11);
   localparam logic [ALUOP_W-1:0] OP_LW    = ALUOP_W'(6'd12);
   localparam logic [ALUOP_W-1:0] OP_SW    = ALUOP_W'(6'd13);
   localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(6'd14);
   localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(6'd15);
   localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(6'd16);
   localparam logic [ALUOP_W-1:0] OP_BNE   = ALUOP_W'(6'd17);
   localparam logic [ALUOP_W-1:0] OP_BGE   = ALUOP_W'(6'd18);
   localparam logic [ALUOP_W-1:0] OP_BLTU  = ALUOP_W'(6'd19);
   localparam logic [ALUOP_W-1:0] OP_BGEU  = ALUOP_W'(6'd20);
   localparam logic [ALUOP_W-1:0] OP_JALR  = ALUOP_W'(6'd21);
   localparam logic [ALUOP_W-1:0] OP_LUI   = ALUOP_W'(6'd22);
   localparam logic [ALUOP_W-1:0] OP_AUIPC = ALUOP_W'(6'd23);
   localparam logic [ALUOP_W-1:0] OP_LB    = ALUOP_W'(6'd24);
   localparam logic [ALUOP_W-1:0] OP_LH    = ALUOP_W'(6'd25);
   localparam logic [ALUOP_W-1:0] OP_LBU   = ALUOP_W'(6'd26);
   localparam logic [ALUOP_W-1:0] OP_LHU   = ALUOP_W'(6'd27);
   localparam logic [ALUOP_W-1:0] OP_SB    = ALUOP_W'(6'd28);
   localparam logic [ALUOP_W-1:0] OP_SH    = ALUOP_W'(6'd29);
`ifdef DECODE_RV32M_EN
   localparam logic [ALUOP_W-1:0] OP_MUL    = ALUOP_W'(6'd32);
   localparam logic [ALUOP_W-1:0] OP_MULH   = ALUOP_W'(6'd33);
   localparam logic [ALUOP_W-1:0] OP_MULHSU = ALUOP_W'(6'd34);
   localparam logic [ALUOP_W-1:0] OP_MULHU  = ALUOP_W'(6'd35);
   localparam logic [ALUOP_W-1:0] OP_DIV    = ALUOP_W'(6'd36);
   localparam logic [ALUOP_W-1:0] OP_DIVU   = ALUOP_W'(6'd37);
   localparam logic [ALUOP_W-1:0] OP_REM    = ALUOP_W'(6'd38);
   localparam logic [ALUOP_W-1:0] OP_REMU   = ALUOP_W'(6'd39);
`endif

   // Major opcodes of the base set
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_t;

   typedef struct packed {
      logic [ALUOP_W-1:0] aluop;
      logic [4:0]         rs1;
      logic [4:0]         rs2;
      logic [4:0]         rd;
      logic               rs1_en;
      logic               rs2_en;
      logic               rd_we;
      logic [XLEN-1:0]    imm;
      logic [XLEN-1:0]    pc;
      logic               illegal;
   } bundle_t;

   logic [6:0]         w_opcode;
   logic [2:0]         w_funct3;
   logic [6:0]         w_funct7;
   logic [ALUOP_W-1:0] w_op;
   fmt_t               w_fmt;
   logic               w_legal;
   logic [31:0]        w_imm32;
   bundle_t            w_dec;

   bundle_t            r_out_b;
   bundle_t            r_skid_b;
   logic               r_out_valid;
   logic               r_skid_valid;
   logic               r_in_ready;

   bundle_t            w_out_nxt;
   bundle_t            w_skid_nxt;
   logic               w_out_valid_nxt;
   logic               w_skid_valid_nxt;
   logic               w_in_fire;

   assign w_opcode  = in_instr[6:0];
   assign w_funct3  = in_instr[14:12];
   assign w_funct7  = in_instr[31:25];
   assign w_in_fire = in_valid && r_in_ready;

   // Opcode/funct decode into an op code, an instruction format and a legality flag
   always_comb begin
      w_op    = OP_NONE;
      w_fmt   = FMT_R;
      w_legal = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_op = OP_LUI; w_fmt = FMT_U; w_legal = 1'b1;
         end
         OPC_AUIPC: begin
            w_op = OP_AUIPC; w_fmt = FMT_U; w_legal = 1'b1;
         end
         OPC_JAL: begin
            w_op = OP_JAL; w_fmt = FMT_J; w_legal = 1'b1;
         end
         OPC_JALR: begin
            w_op = OP_JALR; w_fmt = FMT_I; w_legal = (w_funct3 == 3'b000);
         end
         OPC_BRANCH: begin
            w_fmt = FMT_B; w_legal = 1'b1;
            case (w_funct3)
               3'b000:  w_op = OP_BEQ;
               3'b001:  w_op = OP_BNE;
               3'b100:  w_op = OP_BLT;
               3'b101:  w_op = OP_BGE;
               3'b110:  w_op = OP_BLTU;
               3'b111:  w_op = OP_BGEU;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            w_fmt = FMT_I; w_legal = 1'b1;
            case (w_funct3)
               3'b000:  w_op = OP_LB;
               3'b001:  w_op = OP_LH;
               3'b010:  w_op = OP_LW;
               3'b100:  w_op = OP_LBU;
               3'b101:  w_op = OP_LHU;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            w_fmt = FMT_S; w_legal = 1'b1;
            case (w_funct3)
               3'b000:  w_op = OP_SB;
               3'b001:  w_op = OP_SH;
               3'b010:  w_op = OP_SW;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_OPIMM: begin
            w_fmt = FMT_I; w_legal = 1'b1;
            case (w_funct3)
               3'b000: w_op = OP_ADDI;
               3'b010: w_op = OP_SLT;
               3'b011: w_op = OP_SLTU;
               3'b100: w_op = OP_XOR;
               3'b110: w_op = OP_OR;
               3'b111: w_op = OP_AND;
               3'b001: begin
                  w_op = OP_SLL; w_legal = (w_funct7 == 7'b0000000);
               end
               3'b101: begin
                  if (w_funct7 == 7'b0000000) begin
                     w_op = OP_SRL;
                  end else if (w_funct7 == 7'b0100000) begin
                     w_op = OP_SRA;
                  end else begin
                     w_legal = 1'b0;
                  end
               end
               default: w_legal = 1'b0;
            endcase
         end
         OPC_OP: begin
            w_fmt = FMT_R;
            if (w_funct7 == 7'b0000000) begin
               w_legal = 1'b1;
               case (w_funct3)
                  3'b000:  w_op = OP_ADD;
                  3'b001:  w_op = OP_SLL;
                  3'b010:  w_op = OP_SLT;
                  3'b011:  w_op = OP_SLTU;
                  3'b100:  w_op = OP_XOR;
                  3'b101:  w_op = OP_SRL;
                  3'b110:  w_op = OP_OR;
                  3'b111:  w_op = OP_AND;
                  default: w_legal = 1'b0;
               endcase
            end else if (w_funct7 == 7'b0100000) begin
               w_legal = 1'b1;
               case (w_funct3)
                  3'b000:  w_op = OP_SUB;
                  3'b101:  w_op = OP_SRA;
                  default: w_legal = 1'b0;
               endcase
            end
`ifdef DECODE_RV32M_EN
            else if (w_funct7 == 7'b0000001) begin
               w_legal = 1'b1;
               case (w_funct3)
                  3'b000:  w_op = OP_MUL;
                  3'b001:  w_op = OP_MULH;
                  3'b010:  w_op = OP_MULHSU;
                  3'b011:  w_op = OP_MULHU;
                  3'b100:  w_op = OP_DIV;
                  3'b101:  w_op = OP_DIVU;
                  3'b110:  w_op = OP_REM;
                  3'b111:  w_op = OP_REMU;
                  default: w_legal = 1'b0;
               endcase
            end
`endif
            else begin
               w_legal = 1'b0;
            end
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   // 32-bit immediate assembly per format; sign extension to XLEN happens below
   always_comb begin
      w_imm32 = 32'd0;
      case (w_fmt)
         FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U:   w_imm32 = {in_instr[31:12], 12'd0};
         FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
   end

   // Bundle assembly; an illegal instruction keeps its specifiers but enables nothing
   always_comb begin
      w_dec         = '0;
      w_dec.rs1     = in_instr[19:15];
      w_dec.rs2     = in_instr[24:20];
      w_dec.rd      = in_instr[11:7];
      w_dec.pc      = in_pc;
      w_dec.illegal = !w_legal;
      if (w_legal) begin
         w_dec.aluop  = w_op;
         w_dec.imm    = XLEN'($signed(w_imm32));
         w_dec.rs1_en = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                        (w_fmt == FMT_S) || (w_fmt == FMT_B);
         w_dec.rs2_en = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
         w_dec.rd_we  = ((w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                         (w_fmt == FMT_U) || (w_fmt == FMT_J)) &&
                        (in_instr[11:7] != 5'd0);
      end else begin
         w_dec.aluop  = OP_NONE;
         w_dec.imm    = '0;
         w_dec.rs1_en = 1'b0;
         w_dec.rs2_en = 1'b0;
         w_dec.rd_we  = 1'b0;
      end
   end

   // Next state of the output/skid pair; flush wins over both handshakes
   always_comb begin
      w_out_nxt        = r_out_b;
      w_out_valid_nxt  = r_out_valid;
      w_skid_nxt       = r_skid_b;
      w_skid_valid_nxt = r_skid_valid;
      if (flush) begin
         w_out_valid_nxt  = 1'b0;
         w_skid_valid_nxt = 1'b0;
      end else if (!r_out_valid || out_ready) begin
         // Output slot is free after this edge: refill from skid first, else from input
         if (r_skid_valid) begin
            w_out_nxt        = r_skid_b;
            w_out_valid_nxt  = 1'b1;
            w_skid_valid_nxt = 1'b0;
         end else if (w_in_fire) begin
            w_out_nxt       = w_dec;
            w_out_valid_nxt = 1'b1;
         end else begin
            w_out_valid_nxt = 1'b0;
         end
      end else begin
         // Output stalled: an accepted beat parks in the skid register
         if (w_in_fire) begin
            w_skid_nxt       = w_dec;
            w_skid_valid_nxt = 1'b1;
         end else begin
            w_skid_valid_nxt = r_skid_valid;
         end
      end
   end

   // Buffer state registers; in_ready is registered as "skid will be empty"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_b      <= '0;
         r_skid_b     <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_out_b      <= w_out_nxt;
         r_skid_b     <= w_skid_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= !w_skid_valid_nxt;
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_aluop   = r_out_b.aluop;
   assign out_rs1     = r_out_b.rs1;
   assign out_rs2     = r_out_b.rs2;
   assign out_rd      = r_out_b.rd;
   assign out_rs1_en  = r_out_b.rs1_en;
   assign out_rs2_en  = r_out_b.rs2_en;
   assign out_rd_we   = r_out_b.rd_we;
   assign out_imm     = r_out_b.imm;
   assign out_pc      = r_out_b.pc;
   assign out_illegal = r_out_b.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage. Random instructions are built
// by an encoder from a mnemonic table with a chosen immediate value, so the
// expected bundle comes from what was encoded, not from a second decoder.
module tb_id_stage;
   localparam int XLEN    = 32;
   localparam int ALUOP_W = 6;

   localparam int F_R  = 0;
   localparam int F_I  = 1;
   localparam int F_SH = 2;
   localparam int F_S  = 3;
   localparam int F_B  = 4;
   localparam int F_U  = 5;
   localparam int F_J  = 6;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_instr;
   logic [XLEN-1:0]    in_pc;
   logic               out_valid;
   logic               out_ready;
   logic [ALUOP_W-1:0] out_aluop;
   logic [4:0]         out_rs1;
   logic [4:0]         out_rs2;
   logic [4:0]         out_rd;
   logic               out_rs1_en;
   logic               out_rs2_en;
   logic               out_rd_we;
   logic [XLEN-1:0]    out_imm;
   logic [XLEN-1:0]    out_pc;
   logic               out_illegal;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         code;
      int         fmt;
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
   } op_t;

   typedef struct packed {
      logic [5:0]  aluop;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rs1_en;
      logic        rs2_en;
      logic        rd_we;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        illegal;
   } exp_t;

   op_t ops[$];

   id_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we),
      .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   function automatic op_t mk(int code, int fmt, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
      op_t o;
      o.code = code; o.fmt = fmt; o.opc = opc; o.f3 = f3; o.f7 = f7;
      return o;
   endfunction

   task automatic init_table();
      ops.push_back(mk( 1, F_R,  7'b0110011, 3'b000, 7'b0000000));
      ops.push_back(mk( 2, F_R,  7'b0110011, 3'b000, 7'b0100000));
      ops.push_back(mk( 3, F_R,  7'b0110011, 3'b001, 7'b0000000));
      ops.push_back(mk(14, F_R,  7'b0110011, 3'b010, 7'b0000000));
      ops.push_back(mk(15, F_R,  7'b0110011, 3'b011, 7'b0000000));
      ops.push_back(mk( 8, F_R,  7'b0110011, 3'b100, 7'b0000000));
      ops.push_back(mk(11, F_R,  7'b0110011, 3'b101, 7'b0000000));
      ops.push_back(mk(16, F_R,  7'b0110011, 3'b101, 7'b0100000));
      ops.push_back(mk( 7, F_R,  7'b0110011, 3'b110, 7'b0000000));
      ops.push_back(mk( 6, F_R,  7'b0110011, 3'b111, 7'b0000000));
      ops.push_back(mk( 5, F_I,  7'b0010011, 3'b000, 7'b0000000));
      ops.push_back(mk(14, F_I,  7'b0010011, 3'b010, 7'b0000000));
      ops.push_back(mk(15, F_I,  7'b0010011, 3'b011, 7'b0000000));
      ops.push_back(mk( 8, F_I,  7'b0010011, 3'b100, 7'b0000000));
      ops.push_back(mk( 7, F_I,  7'b0010011, 3'b110, 7'b0000000));
      ops.push_back(mk( 6, F_I,  7'b0010011, 3'b111, 7'b0000000));
      ops.push_back(mk( 3, F_SH, 7'b0010011, 3'b001, 7'b0000000));
      ops.push_back(mk(11, F_SH, 7'b0010011, 3'b101, 7'b0000000));
      ops.push_back(mk(16, F_SH, 7'b0010011, 3'b101, 7'b0100000));
      ops.push_back(mk(24, F_I,  7'b0000011, 3'b000, 7'b0000000));
      ops.push_back(mk(25, F_I,  7'b0000011, 3'b001, 7'b0000000));
      ops.push_back(mk(12, F_I,  7'b0000011, 3'b010, 7'b0000000));
      ops.push_back(mk(26, F_I,  7'b0000011, 3'b100, 7'b0000000));
      ops.push_back(mk(27, F_I,  7'b0000011, 3'b101, 7'b0000000));
      ops.push_back(mk(21, F_I,  7'b1100111, 3'b000, 7'b0000000));
      ops.push_back(mk(28, F_S,  7'b0100011, 3'b000, 7'b0000000));
      ops.push_back(mk(29, F_S,  7'b0100011, 3'b001, 7'b0000000));
      ops.push_back(mk(13, F_S,  7'b0100011, 3'b010, 7'b0000000));
      ops.push_back(mk(10, F_B,  7'b1100011, 3'b000, 7'b0000000));
      ops.push_back(mk(17, F_B,  7'b1100011, 3'b001, 7'b0000000));
      ops.push_back(mk( 9, F_B,  7'b1100011, 3'b100, 7'b0000000));
      ops.push_back(mk(18, F_B,  7'b1100011, 3'b101, 7'b0000000));
      ops.push_back(mk(19, F_B,  7'b1100011, 3'b110, 7'b0000000));
      ops.push_back(mk(20, F_B,  7'b1100011, 3'b111, 7'b0000000));
      ops.push_back(mk(22, F_U,  7'b0110111, 3'b000, 7'b0000000));
      ops.push_back(mk(23, F_U,  7'b0010111, 3'b000, 7'b0000000));
      ops.push_back(mk( 4, F_J,  7'b1101111, 3'b000, 7'b0000000));
`ifdef DECODE_RV32M_EN
      for (int k = 0; k < 8; k++) begin
         ops.push_back(mk(32 + k, F_R, 7'b0110011, 3'(k), 7'b0000001));
      end
`endif
   endtask

   // Encode a random instance of mnemonic o; e is what the decoder must produce.
   function automatic void gen(input op_t o, output logic [31:0] w, output exp_t e);
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      int          iv;
      int          sh;
      longint      lv;
      rd  = 5'($urandom_range(31));
      rs1 = 5'($urandom_range(31));
      rs2 = 5'($urandom_range(31));
      e   = '0;
      w   = 32'd0;
      case (o.fmt)
         F_R: begin
            w = {o.f7, rs2, rs1, o.f3, rd, o.opc};
            e.imm = 32'd0;
         end
         F_I: begin
            iv = int'($urandom_range(4095)) - 2048;
            w = {iv[11:0], rs1, o.f3, rd, o.opc};
            e.imm = iv;
         end
         F_SH: begin
            sh = int'($urandom_range(31));
            w = {o.f7, sh[4:0], rs1, o.f3, rd, o.opc};
            e.imm = 32'(int'(o.f7) * 32 + sh);
         end
         F_S: begin
            iv = int'($urandom_range(4095)) - 2048;
            w = {iv[11:5], rs2, rs1, o.f3, iv[4:0], o.opc};
            e.imm = iv;
         end
         F_B: begin
            iv = (int'($urandom_range(4095)) - 2048) * 2;
            w = {iv[12], iv[10:5], rs2, rs1, o.f3, iv[4:1], iv[11], o.opc};
            e.imm = iv;
         end
         F_U: begin
            lv = longint'($urandom_range(1048575));
            w = {lv[19:0], rd, o.opc};
            e.imm = 32'(lv * 64'd4096);
         end
         default: begin
            iv = (int'($urandom_range(1048575)) - 524288) * 2;
            w = {iv[20], iv[10:1], iv[11], iv[19:12], rd, o.opc};
            e.imm = iv;
         end
      endcase
      e.aluop   = 6'(o.code);
      e.rs1     = w[19:15];
      e.rs2     = w[24:20];
      e.rd      = w[11:7];
      e.rs1_en  = (o.fmt == F_R) || (o.fmt == F_I) || (o.fmt == F_SH) ||
                  (o.fmt == F_S) || (o.fmt == F_B);
      e.rs2_en  = (o.fmt == F_R) || (o.fmt == F_S) || (o.fmt == F_B);
      e.rd_we   = ((o.fmt == F_R) || (o.fmt == F_I) || (o.fmt == F_SH) ||
                   (o.fmt == F_U) || (o.fmt == F_J)) && (w[11:7] != 5'd0);
      e.illegal = 1'b0;
      e.pc      = $urandom;
      e.pc[1:0] = 2'd0;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.aluop = out_aluop; o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd = out_rd;
      o.rs1_en = out_rs1_en; o.rs2_en = out_rs2_en; o.rd_we = out_rd_we;
      o.imm = out_imm; o.pc = out_pc; o.illegal = out_illegal;
      return o;
   endfunction

   task automatic drive_one(input logic [31:0] w, input logic [31:0] pc);
      in_valid = 1'b1; in_instr = w; in_pc = pc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'd0; in_pc = 32'd0;
      #1 rst_n = 1'b0;
      #2;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (observe() !== exp_t'(0)) begin bad++; $display("FAIL reset_outs got=%h want=0", observe()); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_idle got valid=%b ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_directed();
      out_ready = 1'b1;
      drive_one(32'h002081B3, 32'h0000_0040);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
      total++; if (out_aluop !== 6'd1 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd3) begin
         bad++; $display("FAIL add_fields got op=%0d rs1=%0d rs2=%0d rd=%0d want 1/1/2/3", out_aluop, out_rs1, out_rs2, out_rd);
      end
      total++; if (out_rd_we !== 1'b1 || out_imm !== 32'd0 || out_pc !== 32'h40) begin
         bad++; $display("FAIL add_we_imm got we=%b imm=%h pc=%h want 1/0/40", out_rd_we, out_imm, out_pc);
      end
      drive_one(32'hFFF00013, 32'h0000_0044);
      total++; if (out_aluop !== 6'd5 || out_imm !== 32'hFFFF_FFFF || out_rd_we !== 1'b0 || out_rs1_en !== 1'b1) begin
         bad++; $display("FAIL addi_x0 got op=%0d imm=%h we=%b rs1en=%b want 5/ffffffff/0/1", out_aluop, out_imm, out_rd_we, out_rs1_en);
      end
      drive_one(32'hFFDFF0EF, 32'h0000_0048);
      total++; if (out_aluop !== 6'd4 || out_imm !== 32'hFFFF_FFFC || out_rd_we !== 1'b1 || out_rd !== 5'd1) begin
         bad++; $display("FAIL jal got op=%0d imm=%h we=%b rd=%0d want 4/fffffffc/1/1", out_aluop, out_imm, out_rd_we, out_rd);
      end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL directed_drain got=%b want=0", out_valid); end
   endtask

   task automatic test_skid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready0 got=%b want=1", in_ready); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || in_ready !== 1'b1) begin
         bad++; $display("FAIL skid_first got v=%b pc=%h rdy=%b want 1/100/1", out_valid, out_pc, in_ready);
      end
      in_instr = 32'h402081B3; in_pc = 32'h104;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0 || out_pc !== 32'h100) begin
         bad++; $display("FAIL skid_full got rdy=%b pc=%h want 0/100", in_ready, out_pc);
      end
      in_instr = 32'h0020C1B3; in_pc = 32'h108;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0 || out_pc !== 32'h100 || out_aluop !== 6'd1) begin
         bad++; $display("FAIL skid_hold got rdy=%b pc=%h op=%0d want 0/100/1", in_ready, out_pc, out_aluop);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_aluop !== 6'd2 || in_ready !== 1'b1) begin
         bad++; $display("FAIL skid_second got v=%b pc=%h op=%0d rdy=%b want 1/104/2/1", out_valid, out_pc, out_aluop, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_aluop !== 6'd8) begin
         bad++; $display("FAIL skid_third got v=%b pc=%h op=%0d want 1/108/8", out_valid, out_pc, out_aluop);
      end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_empty got=%b want=0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300;
      @(posedge clk); #1;
      in_pc = 32'h304;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got rdy=%b want=0", in_ready); end
      flush = 1'b1; in_pc = 32'h308;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL flush_clear got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost cycle=%0d got v=%b want=0", k, out_valid); end
      end
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h30C;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got v=%b want=0", out_valid); end
   endtask

   task automatic test_illegal();
      logic [31:0] w;
      out_ready = 1'b1;
      drive_one(32'hFFFF_FFFF, 32'h400);
      total++; if (out_illegal !== 1'b1 || out_aluop !== 6'd0 || out_rd_we !== 1'b0 || out_rs1_en !== 1'b0 || out_rs2_en !== 1'b0) begin
         bad++; $display("FAIL ill_ones got ill=%b op=%0d we=%b en=%b%b want 1/0/0/00", out_illegal, out_aluop, out_rd_we, out_rs1_en, out_rs2_en);
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ill_delivered got v=%b want=1", out_valid); end
      drive_one(32'h022081B3, 32'h404);
`ifdef DECODE_RV32M_EN
      total++; if (out_illegal !== 1'b0 || out_aluop !== 6'd32 || out_rd_we !== 1'b1 || out_rs2_en !== 1'b1) begin
         bad++; $display("FAIL mul_m got ill=%b op=%0d we=%b rs2en=%b want 0/32/1/1", out_illegal, out_aluop, out_rd_we, out_rs2_en);
      end
`else
      total++; if (out_illegal !== 1'b1 || out_aluop !== 6'd0 || out_rd_we !== 1'b0) begin
         bad++; $display("FAIL mul_base got ill=%b op=%0d we=%b want 1/0/0", out_illegal, out_aluop, out_rd_we);
      end
`endif
      w = {7'b0100000, 5'd1, 5'd1, 3'b001, 5'd1, 7'b0010011};
      drive_one(w, 32'h408);
      total++; if (out_illegal !== 1'b1 || out_aluop !== 6'd0 || out_rd !== 5'd1 || out_rd_we !== 1'b0) begin
         bad++; $display("FAIL slli_badf7 got ill=%b op=%0d rd=%0d we=%b want 1/0/1/0", out_illegal, out_aluop, out_rd, out_rd_we);
      end
      w = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011};
      drive_one(w, 32'h40C);
      total++; if (out_illegal !== 1'b1 || out_aluop !== 6'd0 || out_rs1_en !== 1'b0) begin
         bad++; $display("FAIL branch_f3 got ill=%b op=%0d rs1en=%b want 1/0/0", out_illegal, out_aluop, out_rs1_en);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random_stream();
      exp_t        q[$];
      exp_t        cur_e;
      exp_t        obs;
      logic [31:0] cur_w;
      int          guard;
      gen(ops[$urandom_range(ops.size() - 1)], cur_w, cur_e);
      for (int c = 0; c < 800; c++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         in_instr  = cur_w;
         in_pc     = cur_e.pc;
         if (out_valid && out_ready) begin
            obs = observe();
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL stream_extra got=%h want none", obs);
            end else begin
               if (obs !== q[0]) begin
                  bad++; $display("FAIL stream_bundle instr_at_cycle=%0d got=%h want=%h", c, obs, q[0]);
               end
               void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(cur_e);
            gen(ops[$urandom_range(ops.size() - 1)], cur_w, cur_e);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      guard = 0;
      while (q.size() != 0 && guard < 10) begin
         if (out_valid) begin
            obs = observe();
            total++;
            if (obs !== q[0]) begin
               bad++; $display("FAIL stream_drain got=%h want=%h", obs, q[0]);
            end
            void'(q.pop_front());
         end
         @(posedge clk); #1;
         guard++;
      end
      total++; if (q.size() != 0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL stream_lost got pending=%0d v=%b want 0/0", q.size(), out_valid);
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive_one(32'h002081B3, 32'h200);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got v=%b want=1", out_valid); end
      #3 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0 || out_aluop !== 6'd0) begin
         bad++; $display("FAIL areset_async got v=%b rdy=%b pc=%h op=%0d want 0/1/0/0", out_valid, in_ready, out_pc, out_aluop);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_post got v=%b want=0", out_valid); end
   endtask

   initial begin
      init_table();
      test_reset();
      test_directed();
      test_skid();
      test_flush();
      test_illegal();
      test_random_stream();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
